// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants for the serial pattern generator and detector
// Purpose: reference pattern used by generator tests and the sequence detector,
//          plus the FSM state width shared by blocks that keep a local encoding.
// Ports:   none (package)
package seq_pkg;

  localparam logic [2:0] SEQ_PATTERN = 3'b101;
  localparam int         SEQ_LEN     = 3;
  localparam int         STATE_W     = 2;

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-in/serial-out shift register with reload copy
// Purpose: holds the bits still to be sent after the one currently on the line,
//          plus a copy of the full aligned pattern for repeat passes.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   load, load_data    capture a new aligned pattern (and its copy)
//   reload             restart from the stored copy
//   shift              advance by one bit
//   msb                next bit to send from the working register
//   reload_msb         first bit of the stored copy
module piso_shift_reg
  import seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             reload,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             msb,
  output logic             reload_msb
);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] copy_q, copy_d;

  // The first bit of a pass is registered onto the line by the caller in the
  // same edge as load/reload, so the working register skips it here.
  always_comb begin
    shreg_d = shreg_q;
    copy_d  = copy_q;
    if (load) begin
      copy_d  = load_data;
      shreg_d = load_data << 1;
    end else if (reload) begin
      shreg_d = copy_q << 1;
    end else if (shift) begin
      shreg_d = shreg_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      copy_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      copy_q  <= copy_d;
    end
  end

  assign msb        = shreg_q[WIDTH-1];
  assign reload_msb = copy_q[WIDTH-1];

endmodule

// File: rtl/seq_generator.sv
// rtl/seq_generator.sv - serial bit-pattern transmitter, MSB-first with repeats
// Purpose: accepts pattern/len/rpt on a valid/ready load, then sends
//          eff_len*(rpt+1) contiguous valid bits, pulsing done on the last one.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_valid, load_ready   load handshake (ready only in IDLE, not in reset)
//   pattern, len, rpt        bits to send, bits per pass, extra passes
//   abort                    terminate the frame in progress
//   bit_out, bit_valid       registered serial data and qualifier
//   busy                     frame in progress
//   done                     one-cycle pulse with the final bit of the frame
module seq_generator
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH) + 1,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] rpt,
  input  logic             abort,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
  } state_e;

  state_e           state_q, state_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [LEN_W-1:0] eff_len_q, eff_len_d;

  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] align_sh;
  logic [WIDTH-1:0] aligned;
  logic             piso_load, piso_reload, piso_shift;
  logic             piso_msb, piso_reload_msb;

  // Out-of-range lengths fall back to a full-width pass.
  assign eff_len  = ((len == '0) || (len > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : len;
  // Left-align so pattern[eff_len-1] lands in the MSB.
  assign align_sh = LEN_W'(WIDTH) - eff_len;
  assign aligned  = pattern << align_sh;

  assign load_ready = (state_q == IDLE) && !rst;
  assign busy       = (state_q == SEND);
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign done       = done_q;

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (piso_load),
    .reload    (piso_reload),
    .shift     (piso_shift),
    .load_data (aligned),
    .msb       (piso_msb),
    .reload_msb(piso_reload_msb)
  );

  // bit_cnt_q counts the bits of the current pass still on or ahead of the
  // line, so 1 means the bit now visible closes the pass. done is computed one
  // edge early so it lines up with the final registered bit.
  always_comb begin
    state_d     = state_q;
    bit_out_d   = 1'b0;
    bit_valid_d = 1'b0;
    done_d      = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    eff_len_d   = eff_len_q;
    piso_load   = 1'b0;
    piso_reload = 1'b0;
    piso_shift  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid && load_ready) begin
          state_d     = SEND;
          piso_load   = 1'b1;
          bit_out_d   = aligned[WIDTH-1];
          bit_valid_d = 1'b1;
          eff_len_d   = eff_len;
          bit_cnt_d   = eff_len;
          pass_cnt_d  = rpt;
          done_d      = (eff_len == LEN_W'(1)) && (rpt == '0);
        end
      end
      SEND: begin
        if (abort) begin
          state_d    = IDLE;
          bit_cnt_d  = '0;
          pass_cnt_d = '0;
        end else if (bit_cnt_q == LEN_W'(1)) begin
          if (pass_cnt_q == '0) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            piso_reload = 1'b1;
            bit_out_d   = piso_reload_msb;
            bit_valid_d = 1'b1;
            bit_cnt_d   = eff_len_q;
            pass_cnt_d  = pass_cnt_q - CNT_W'(1);
            done_d      = (eff_len_q == LEN_W'(1)) && (pass_cnt_q == CNT_W'(1));
          end
        end else begin
          piso_shift  = 1'b1;
          bit_out_d   = piso_msb;
          bit_valid_d = 1'b1;
          bit_cnt_d   = bit_cnt_q - LEN_W'(1);
          done_d      = (bit_cnt_q == LEN_W'(2)) && (pass_cnt_q == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
      bit_cnt_q   <= '0;
      pass_cnt_q  <= '0;
      eff_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      done_q      <= done_d;
      bit_cnt_q   <= bit_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      eff_len_q   <= eff_len_d;
    end
  end

endmodule

// File: tb/tb_seq_generator.sv
// tb/tb_seq_generator.sv - self-checking bench for seq_generator
module tb_seq_generator;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] rpt = '0;
  logic       abort = 1'b0;
  logic       bit_out, bit_valid, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  logic q[$];
  logic [63:0] obs_bits = '0;
  int          obs_n = 0;
  int          done_n = 0;

  seq_generator #(.WIDTH(8), .LEN_W(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .pattern   (pattern),
    .len       (len),
    .rpt       (rpt),
    .abort     (abort),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: a frame is the list of bits it will put on the line; one bit is
  // consumed per clock while the list is non-empty.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else if (q.size() > 0) begin
      if (abort) q.delete();
      else void'(q.pop_front());
    end else if (load_valid) begin
      int eff;
      eff = (len == 0 || len > 8) ? 8 : int'(len);
      for (int p = 0; p <= int'(rpt); p++)
        for (int i = eff - 1; i >= 0; i--)
          q.push_back(pattern[i]);
    end
  end

  always @(negedge clk) begin
    logic ev;
    ev = (q.size() > 0);
    chk("bit_valid", bit_valid, ev);
    chk("bit_out", bit_out, ev ? q[0] : 1'b0);
    chk("done", done, q.size() == 1);
    chk("busy", busy, ev);
    chk("load_ready", load_ready, !ev && !rst);
    if (bit_valid === 1'b1) begin
      obs_bits = {obs_bits[62:0], bit_out};
      obs_n++;
    end
    if (done === 1'b1) done_n++;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && q.size() != 0; i++) cycle();
    chk("idle_timeout", q.size() == 0, 1);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    pattern = p; len = l; rpt = r; load_valid = 1'b1;
    cycle();
    load_valid = 1'b0; pattern = 8'($urandom); len = 4'($urandom); rpt = 4'($urandom);
  endtask

  task automatic clr_obs();
    obs_bits = '0; obs_n = 0; done_n = 0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] p, input logic [3:0] l,
                           input logic [3:0] r, input logic [63:0] exp_bits, input int exp_n);
    clr_obs();
    load(p, l, r);
    wait_idle();
    chk({tag, "_bits"}, obs_bits, exp_bits);
    chk({tag, "_n"}, 64'(obs_n), 64'(exp_n));
    chk({tag, "_done"}, 64'(done_n), 64'd1);
  endtask

  initial begin
    load_valid = 1'b1;
    pattern = 8'hFF; len = 4'd4; rpt = 4'd0;
    repeat (3) cycle();
    chk("rst_no_accept", 64'(obs_n), 64'd0);
    rst = 1'b0; load_valid = 1'b0;
    cycle();

    run_frame("seq_pat", {5'b0, SEQ_PATTERN}, 4'(SEQ_LEN), 4'd0, 64'b101, 3);
    run_frame("rpt2", 8'h02, 4'd2, 4'd2, 64'b101010, 6);
    run_frame("len0", 8'hA5, 4'd0, 4'd0, 64'b10100101, 8);
    run_frame("len9", 8'hA5, 4'd9, 4'd0, 64'b10100101, 8);
    run_frame("len1_rpt15", 8'h01, 4'd1, 4'd15, 64'hFFFF, 16);

    clr_obs();
    load(8'hA5, 4'd8, 4'd0);
    cycle(); cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_ready", load_ready, 1'b1);
    chk("abort_n", 64'(obs_n), 64'd3);
    chk("abort_done", 64'(done_n), 64'd0);

    clr_obs();
    load(8'hFF, 4'd8, 4'd1);
    cycle(); cycle();
    rst = 1'b1; load_valid = 1'b1;
    cycle();
    chk("rst_mid_valid", bit_valid, 1'b0);
    cycle();
    rst = 1'b0; load_valid = 1'b0;
    cycle();
    chk("rst_mid_n", 64'(obs_n), 64'd3);
    run_frame("after_rst", 8'h35, 4'd6, 4'd0, 64'b110101, 6);

    clr_obs();
    load(8'h96, 4'd8, 4'd1);
    cycle(); cycle();
    pattern = 8'h00; len = 4'd2; rpt = 4'd0; load_valid = 1'b1;
    cycle();
    load_valid = 1'b0;
    wait_idle();
    chk("ignore_load_bits", obs_bits, 64'h9696);
    chk("ignore_load_done", 64'(done_n), 64'd1);

    for (int c = 0; c < 3000; c++) begin
      load_valid = ($urandom_range(0, 2) == 0);
      pattern    = 8'($urandom);
      len        = 4'($urandom);
      rpt        = 4'($urandom_range(0, 3));
      abort      = ($urandom_range(0, 39) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      cycle();
    end
    load_valid = 1'b0; abort = 1'b0; rst = 1'b0;
    wait_idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_generator.md
# seq_generator

Serial bit-pattern transmitter that drives the single-bit stream the sequence detector consumes. It accepts a parallel pattern, a length and a repeat count through a valid/ready load handshake. It then shifts the pattern out MSB-first, one bit per clock, with a bit-valid qualifier. It is the transmit end of the serial bit interface: a stimulus source in benches and a pattern source in the lab design.

## Interface
- WIDTH, 8, maximum pattern length in bits (≥2)
- LEN_W, $clog2(WIDTH)+1, width of len
- CNT_W, 4, width of repeat count
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  pattern/len/rpt valid this cycle
- load_ready  out  1  generator can accept a load (IDLE and not rst)
- pattern  in  WIDTH  bits to send; pattern[len-1] goes first
- len  in  LEN_W  bits per pass, 1..WIDTH; 0 or >WIDTH treated as WIDTH
- rpt  in  CNT_W  extra passes after the first (total passes = rpt+1)
- abort  in  1  terminate the current frame
- bit_out  out  1  serial data, registered
- bit_valid  out  1  bit_out carries a frame bit, registered
- busy  out  1  frame in progress (state SEND)
- done  out  1  one-cycle pulse coincident with the final bit of the frame

## Operation
- States: IDLE, SEND. 2-bit binary encoding, with default → IDLE.
- Reset (rst=1 at an edge): state IDLE, bit_out=0, bit_valid=0, busy=0, done=0, all counters 0. load_ready=0 while rst is high.
- IDLE: load_ready=1. On load_valid && load_ready, the block captures pattern left-aligned to len into the shift register, a copy into the reload register, eff_len into the bit counter, and rpt into the pass counter. Next state is SEND.
- SEND: each cycle drives shreg MSB to bit_out with bit_valid=1, shifts left, and decrements the bit counter.
  - End of pass (bit counter = 1) with pass counter > 0: decrement the pass counter, reload shreg from the copy and the bit counter from eff_len. The next pass follows with no gap cycle.
  - End of pass with pass counter = 0: done=1 with this bit, then go to IDLE.
- Frame length = eff_len × (rpt+1) consecutive valid bits. Counters must not wrap. rpt = 2^CNT_W−1 is legal.
- abort in SEND: the next cycle is IDLE, with bit_valid=0 and no done pulse. abort in IDLE is ignored. If abort arrives on the final-bit cycle, the final bit and done still appear, because they are already registered.
- load_valid outside IDLE is ignored and not queued. pattern, len and rpt only need to be stable in the handshake cycle.
- In IDLE, bit_out=0 and bit_valid=0.

## Timing
- Load accepted at edge k → first bit valid in cycle k+1. Bit n (0-based) is in cycle k+1+n.
- done is high in the same cycle as the last bit_valid bit. load_ready returns high the cycle after.
- Minimum spacing between frames is one idle cycle: back-to-back loads cannot be accepted during the final bit.
- rst takes priority over abort and load. A reset mid-frame silences bit_valid from the cycle after the reset edge.

## Structure
- Shared package/header seq_pkg:
  - SEQ_PATTERN = 3'b101 and SEQ_LEN = 3, used by the generator tests and the detector.
  - The common state-width localparam.
- State encoding stays local.
- One natural sub-module: piso_shift_reg, a WIDTH-bit parallel-in/serial-out with load, shift and reload. The FSM, bit counter and pass counter live in the top module.

## Test plan
- pattern=8'h05, len=3, rpt=0 → bit_out 1,0,1 in cycles k+1..k+3 with bit_valid=1. done in k+3. When looped into the detector, seq_detected=1 in k+3.
- pattern=8'h02, len=2, rpt=2 → 1,0,1,0,1,0 over 6 contiguous cycles with no gaps. done only on the 6th bit. The detector fires on bits 3 and 5.
- len=0, pattern=8'hA5 → 8 bits 1,0,1,0,0,1,0,1. Also check len=9 gives the same result.
- abort asserted on bit 2 of an 8-bit frame → bit_valid low from the next cycle, done never pulses, load_ready=1 the following cycle.
- rst asserted mid-frame → all outputs 0 after the edge. A load_valid held during reset is not accepted. A new load after reset sends cleanly.
- load_valid pulsed during SEND with different data → ignored, and the current frame completes unchanged.
